// File: rtl/tpu_pkg.sv
// tpu_pkg: shared TPU word, halfword and instruction types.
// Instruction layout, MSB first: operand[63:0], length[7:0], opcode[7:0].
package tpu_pkg;
    localparam int BYTE_WIDTH = 8;
    typedef logic [4*BYTE_WIDTH-1:0] word_type;
    typedef logic [2*BYTE_WIDTH-1:0] halfword_type;
    typedef struct packed {
        logic [8*BYTE_WIDTH-1:0] operand;
        logic [BYTE_WIDTH-1:0]   length;
        logic [BYTE_WIDTH-1:0]   opcode;
    } instr_type;
    localparam instr_type INIT_INSTR = '0;
endpackage

// File: rtl/instr_fifo_lane.sv
// fifo_lane: single-lane show-ahead FIFO with registered empty/full flags.
// Ports: clk, rst (async active-low), push, pop, data (write word),
//        head (word at read pointer), empty, full.
// A pop is ignored when empty, so a push into an empty lane never bypasses.
// A push into a full lane is accepted only when the lane is popped that cycle.
module fifo_lane #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0] count, count_nxt;
    logic do_push, do_pop;
    always_comb begin
        do_pop = pop && !empty;
        do_push = push && (!full || do_pop);
        count_nxt = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            empty <= 1'b1;
            full <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            empty <= count_nxt == '0;
            full <= count_nxt == (AW+1)'(DEPTH);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data;
    end
    assign head = mem[rd_ptr];
endmodule

// File: rtl/instr_fifo.sv
// instr_fifo: 80-bit instruction FIFO built from three independently written lanes.
// Ports: clk, rst (async active-low), enable, lower/middle/upper_instr_word,
//        instr_write_enable (per-lane push), instr_out, instr_valid, instr_ready,
//        instr_fifo_empty, instr_fifo_full.
// Optional macro INSTR_FIFO_ERR_EN adds sticky overflow_err / underflow_err outputs.
// Lane entries pair up by arrival order; an instruction is valid once every lane
// holds at least one entry, and a pop advances all three lanes together.
module instr_fifo import tpu_pkg::*; #(
    parameter int FIFO_DEPTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  word_type     lower_instr_word,
    input  word_type     middle_instr_word,
    input  halfword_type upper_instr_word,
    input  logic [2:0]   instr_write_enable,
    output instr_type    instr_out,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic         instr_fifo_empty,
    output logic         instr_fifo_full
`ifdef INSTR_FIFO_ERR_EN
    ,
    output logic         overflow_err,
    output logic         underflow_err
`endif
);
    logic [2:0] push, empty, full;
    logic pop;
    word_type lower_head, middle_head;
    halfword_type upper_head;
    assign push = enable ? instr_write_enable : 3'b000;
    assign pop = enable && instr_ready && instr_valid;
    fifo_lane #(.WIDTH($bits(word_type)), .DEPTH(FIFO_DEPTH)) lower_lane (
        .clk(clk), .rst(rst), .push(push[0]), .pop(pop), .data(lower_instr_word),
        .head(lower_head), .empty(empty[0]), .full(full[0])
    );
    fifo_lane #(.WIDTH($bits(word_type)), .DEPTH(FIFO_DEPTH)) middle_lane (
        .clk(clk), .rst(rst), .push(push[1]), .pop(pop), .data(middle_instr_word),
        .head(middle_head), .empty(empty[1]), .full(full[1])
    );
    fifo_lane #(.WIDTH($bits(halfword_type)), .DEPTH(FIFO_DEPTH)) upper_lane (
        .clk(clk), .rst(rst), .push(push[2]), .pop(pop), .data(upper_instr_word),
        .head(upper_head), .empty(empty[2]), .full(full[2])
    );
    assign instr_fifo_empty = |empty;
    assign instr_fifo_full = |full;
    assign instr_valid = !instr_fifo_empty;
    // Storage is never reset, so the head is masked while invalid to keep X off the bus.
    assign instr_out = instr_valid ? instr_type'({upper_head, middle_head, lower_head}) : INIT_INSTR;
`ifdef INSTR_FIFO_ERR_EN
    logic [2:0] dropped;
    assign dropped = push & full & ~{3{pop}};
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_err <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            overflow_err <= overflow_err || (|dropped);
            underflow_err <= underflow_err || (enable && instr_ready && !instr_valid);
        end
    end
`endif
endmodule

// File: tb/tb_instr_fifo.sv
// tb_instr_fifo: table-driven and scoreboard checks for instr_fifo.
module tb_instr_fifo;
    import tpu_pkg::*;
    localparam int DEPTH = 32;
    logic clk = 1'b0;
    logic rst, enable, ready, valid, empty, full;
    word_type lower, middle;
    halfword_type upper;
    logic [2:0] we;
    instr_type instr_out;
`ifdef INSTR_FIFO_ERR_EN
    logic overflow_err, underflow_err;
`endif
    int vectors = 0;
    int miscompares = 0;
    instr_type sb[$];

    typedef struct {
        logic       en;
        logic [2:0] we;
        logic       rdy;
        logic [7:0] op;
        logic [7:0] len;
        logic       exp_valid;
        logic       exp_empty;
        logic       exp_full;
        logic       chk_out;
        logic [7:0] exp_op;
        logic [7:0] exp_len;
    } vec_t;
    vec_t tbl[7];

    instr_fifo #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .lower_instr_word(lower), .middle_instr_word(middle), .upper_instr_word(upper),
        .instr_write_enable(we), .instr_out(instr_out), .instr_valid(valid),
        .instr_ready(ready), .instr_fifo_empty(empty), .instr_fifo_full(full)
`ifdef INSTR_FIFO_ERR_EN
        , .overflow_err(overflow_err), .underflow_err(underflow_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic instr_type mk(input logic [7:0] op, input logic [7:0] len);
        instr_type r;
        r.operand = {8{op}};
        r.length = len;
        r.opcode = op;
        return r;
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check80(input string name, input instr_type act, input instr_type exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [2:0] w, input logic r, input instr_type d);
        enable = en;
        we = w;
        ready = r;
        lower = d[31:0];
        middle = d[63:32];
        upper = d[79:64];
    endtask

    task automatic idle;
        drive(1'b1, 3'b000, 1'b0, '0);
    endtask

    task automatic do_reset;
        idle();
        rst = 1'b0;
        tick();
        check1("rst_empty", empty, 1'b1);
        check1("rst_valid", valid, 1'b0);
        check1("rst_full", full, 1'b0);
        tick();
        rst = 1'b1;
        sb.delete();
    endtask

    task automatic push_sb(input instr_type d);
        drive(1'b1, 3'b111, 1'b0, d);
        sb.push_back(d);
        tick();
    endtask

    // Compare the head with the scoreboard front, then pop it.
    task automatic pop_check(input string name);
        check1({name, "_valid"}, valid, 1'b1);
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got %h expected <no entry>", name, instr_out);
        end else begin
            check80(name, instr_out, sb.pop_front());
        end
        drive(1'b1, 3'b000, 1'b1, '0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1'b1, 3'b111, 1'b0, 8'h08, 8'd14, 1'b1, 1'b0, 1'b0, 1'b1, 8'h08, 8'd14};
        tbl[1] = '{1'b0, 3'b111, 1'b1, 8'h09, 8'd1,  1'b1, 1'b0, 1'b0, 1'b1, 8'h08, 8'd14};
        tbl[2] = '{1'b1, 3'b000, 1'b1, 8'h00, 8'd0,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0};
        tbl[3] = '{1'b1, 3'b001, 1'b0, 8'h21, 8'd3,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0};
        tbl[4] = '{1'b1, 3'b010, 1'b0, 8'h21, 8'd3,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0};
        tbl[5] = '{1'b1, 3'b100, 1'b1, 8'h21, 8'd3,  1'b1, 1'b0, 1'b0, 1'b1, 8'h21, 8'd3};
        tbl[6] = '{1'b1, 3'b000, 1'b1, 8'h00, 8'd0,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0};
        rst = 1'b0;
        do_reset();
`ifdef INSTR_FIFO_ERR_EN
        check1("rst_underflow", underflow_err, 1'b0);
        check1("rst_overflow", overflow_err, 1'b0);
`endif
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].en, tbl[i].we, tbl[i].rdy, mk(tbl[i].op, tbl[i].len));
            tick();
            check1($sformatf("tbl%0d_valid", i), valid, tbl[i].exp_valid);
            check1($sformatf("tbl%0d_empty", i), empty, tbl[i].exp_empty);
            check1($sformatf("tbl%0d_full", i), full, tbl[i].exp_full);
            if (tbl[i].chk_out)
                check80($sformatf("tbl%0d_out", i), instr_out, mk(tbl[i].exp_op, tbl[i].exp_len));
        end
        idle();
`ifdef INSTR_FIFO_ERR_EN
        check1("tbl_underflow", underflow_err, 1'b1);
        check1("tbl_overflow", overflow_err, 1'b0);
`endif

        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            push_sb(mk(8'(i), 8'(i ^ 5)));
            check1($sformatf("fill%0d_full", i), full, i == DEPTH - 1);
        end
`ifdef INSTR_FIFO_ERR_EN
        check1("fill_overflow_pre", overflow_err, 1'b0);
`endif
        drive(1'b1, 3'b111, 1'b0, mk(8'hAA, 8'hAA));
        tick();
        idle();
        check1("drop_full", full, 1'b1);
`ifdef INSTR_FIFO_ERR_EN
        check1("drop_overflow", overflow_err, 1'b1);
`endif
        for (int i = 0; i < DEPTH; i++) pop_check($sformatf("drain%0d", i));
        idle();
        check1("drain_empty", empty, 1'b1);
        check1("drain_valid", valid, 1'b0);

        for (int i = 0; i < DEPTH; i++) push_sb(mk(8'(i + 64), 8'd1));
        idle();
        check1("refill_full", full, 1'b1);
        check80("pp_head_before", instr_out, sb.pop_front());
        drive(1'b1, 3'b111, 1'b1, mk(8'h55, 8'h55));
        sb.push_back(mk(8'h55, 8'h55));
        tick();
        idle();
        check1("pp_full", full, 1'b1);
        check80("pp_head_after", instr_out, mk(8'd65, 8'd1));
        for (int i = 0; i < DEPTH; i++) pop_check($sformatf("pp_drain%0d", i));
        idle();
        check1("pp_empty", empty, 1'b1);

        do_reset();
        for (int i = 0; i < 5; i++) push_sb(mk(8'(i + 100), 8'd2));
        idle();
        check1("five_valid", valid, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check1("async_empty", empty, 1'b1);
        check1("async_valid", valid, 1'b0);
        check1("async_full", full, 1'b0);
        sb.delete();
        tick();
        rst = 1'b1;
        push_sb(mk(8'hFF, 8'd7));
        idle();
        pop_check("post_rst_ff");
        idle();
        check1("post_rst_empty", empty, 1'b1);
        check1("post_rst_valid", valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instr_fifo.md
INSTR_FIFO -- requirements
Module: instr_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 32, entries per lane; power of two, at least 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port enable, input, 1 bit: when low, pushes and pops are suppressed and state holds.
REQ-005 SHALL have port lower_instr_word, input, word_type (32 bits): instruction bits [31:0].
REQ-006 SHALL have port middle_instr_word, input, word_type (32 bits): instruction bits [63:32].
REQ-007 SHALL have port upper_instr_word, input, halfword_type (16 bits): instruction bits [79:64].
REQ-008 SHALL have port instr_write_enable, input, 3 bits: per-lane push; bit0 lower, bit1 middle, bit2 upper.
REQ-009 SHALL have port instr_out, output, instr_type (80 bits): head instruction, {upper, middle, lower}.
REQ-010 SHALL have port instr_valid, output, 1 bit: a complete instruction is at the head.
REQ-011 SHALL have port instr_ready, input, 1 bit: consumer pop request.
REQ-012 SHALL have port instr_fifo_empty, output, 1 bit: at least one lane is empty.
REQ-013 SHALL have port instr_fifo_full, output, 1 bit: at least one lane is full.

Function
REQ-014 SHALL hold three independent lane FIFOs (32, 32 and 16 bits wide), each FIFO_DEPTH deep, each with its own read pointer, write pointer and count.
REQ-015 SHALL push a lane's word when enable=1, its instr_write_enable bit=1, and the lane is not full (or is popped in the same cycle).
REQ-016 SHALL allow lanes to be written in different cycles; lane entries pair up by order of arrival.
REQ-017 SHALL drive instr_fifo_empty = OR of lane-empty flags, instr_fifo_full = OR of lane-full flags, instr_valid = NOT instr_fifo_empty; all registered from counts.
REQ-018 SHALL present the head entries combinationally from storage (show-ahead); instr_out is don't-care while instr_valid=0.
REQ-019 SHALL pop all three lanes together when enable=1, instr_ready=1 and instr_valid=1; pop while empty is ignored.
REQ-020 SHALL make a push in cycle N visible at the outputs in cycle N+1: instr_valid rises one cycle after the last of the three lanes is written.
REQ-021 SHALL, on simultaneous push and pop of a full lane, accept the push and leave that lane's count unchanged.
REQ-022 SHALL, on simultaneous push and pop of an empty lane, not pop (no bypass) and make the count 1.
REQ-023 SHALL drop a push to a full lane that is not popped that cycle; the stored data is unchanged.
REQ-024 SHALL wrap pointers modulo FIFO_DEPTH.

Reset
REQ-025 SHALL, on rst low (asynchronous), clear all pointers and counts; instr_fifo_empty=1, instr_valid=0, instr_fifo_full=0; storage is not cleared.
REQ-026 SHALL discard all stored entries on reset mid-operation; the first push after rst deasserts is accepted normally.

Configuration
REQ-027 SHALL, with INSTR_FIFO_ERR_EN defined, add output overflow_err, 1 bit: sticky, set the cycle after a dropped push (REQ-023).
REQ-028 SHALL, with INSTR_FIFO_ERR_EN defined, add output underflow_err, 1 bit: sticky, set the cycle after instr_ready=1 with enable=1 while empty; both flags cleared only by rst.
REQ-029 SHALL, without INSTR_FIFO_ERR_EN, have neither port and no related logic; all other behaviour is identical.

Structure
REQ-030 SHALL take word_type, halfword_type, instr_type, BYTE_WIDTH and INIT_INSTR from tpu_pkg; no new package types.
REQ-031 SHALL instantiate sub-module fifo_lane (parameters WIDTH and DEPTH) three times; instr_fifo holds only the combine and flag logic.

Verification
REQ-032 SHALL cover: reset, then all three lanes written in one cycle with opcode 0x08, length 14 -> instr_valid=1 next cycle, instr_out.opcode=0x08, length=14.
REQ-033 SHALL cover: lower lane written in cycle 1, middle in cycle 2, upper in cycle 3 -> instr_valid stays 0 until cycle 4, then instr_out is correctly assembled.
REQ-034 SHALL cover: 32 pushes of opcodes 0..31 with no pops -> instr_fifo_full=1; the 33rd push is dropped (overflow_err=1 when enabled); 32 pops return opcodes 0..31 in order.
REQ-035 SHALL cover: FIFO full with push and pop in the same cycle -> full stays 1; the head advances; the new entry is read last.
REQ-036 SHALL cover: rst pulled low while 5 entries are held -> empty=1 immediately (asynchronous); instr_valid=0; a subsequent push of opcode 0xFF is read back as the only entry.
REQ-037 SHALL cover: enable=0 with write enables 3'b111 and instr_ready=1 -> counts and outputs unchanged.
